// File: rtl/clock_divider_mc.sv
// -----------------------------------------------------------------------------
// clock_divider_mc
//
// Multi-channel programmable clock divider. Each of NUM_CH channels divides
// clk_in by its own runtime WIDTH-bit divisor N (odd or even). The divided
// clock is high for ceil(N/2) cycles and low for the rest. Divisors with N < 2
// put the channel in bypass, where clk_out follows clk_in.
//
// New divisors arrive through a valid/ready config port, park in a per-channel
// pending register, and take effect only on a period boundary (counter wrap,
// enable rising, or a phase-sync request), so no runt pulses are produced.
//
// Optional build macro:
//   PHASE_SYNC_EN - adds input sync_req. A pulse restarts every enabled
//                   divide-mode channel on the same edge, phase-aligning them.
//                   Without the macro the port does not exist.
// -----------------------------------------------------------------------------
module clock_divider_mc #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
`ifdef PHASE_SYNC_EN
    ,
    input  logic              sync_req
`endif
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    // What a channel does on the coming edge.
    typedef enum logic [1:0] {
        CH_OFF,      // disabled: hold counter at 0, output low
        CH_BYPASS,   // N < 2: output follows clk_in, apply pending at once
        CH_RESTART,  // period boundary: apply pending, start a fresh high phase
        CH_RUN       // ordinary counting inside a period
    } ch_mode_e;

    // Per-channel state.
    logic [WIDTH-1:0]  div_q  [NUM_CH];
    logic [WIDTH-1:0]  div_d  [NUM_CH];
    logic [WIDTH-1:0]  pdiv_q [NUM_CH];
    logic [WIDTH-1:0]  pdiv_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q  [NUM_CH];
    logic [WIDTH-1:0]  cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] en_prev_q;

    logic sync;
    logic accept;

`ifdef PHASE_SYNC_EN
    assign sync = sync_req;
`else
    assign sync = 1'b0;
`endif

    // High time of a period: ceil(N/2), kept in WIDTH bits.
    function automatic logic [WIDTH-1:0] high_time(input logic [WIDTH-1:0] n);
        return n - (n >> 1);
    endfunction

    // Config port is ready when the addressed channel exists and has no
    // divisor waiting; an out-of-range channel matches nothing and stays low.
    always_comb begin
        cfg_ready = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (cfg_ch == CH_W'(ch)) begin
                cfg_ready = !pend_q[ch];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;

    // Next-state logic for every channel: mode decode, counter, output and
    // tick generation, divisor apply, and capture of accepted writes.
    always_comb begin
        ch_mode_e         mode;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] n_new;
        logic [WIDTH-1:0] c_nxt;
        logic             wrap;
        logic             restart;

        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        clk_d   = clk_q;
        tick_d  = tick_q;
        mode    = CH_OFF;
        n       = '0;
        n_new   = '0;
        c_nxt   = '0;
        wrap    = 1'b0;
        restart = 1'b0;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            n       = div_q[ch];
            wrap    = (cnt_q[ch] >= n - ONE);
            // A fresh period starts on enable rising, on a sync request, or
            // on a wrap that has a new divisor waiting.
            restart = !en_prev_q[ch] || sync || (wrap && pend_q[ch]);
            n_new   = pend_q[ch] ? pdiv_q[ch] : n;

            if (!ch_en[ch]) begin
                mode = CH_OFF;
            end else if (n < TWO) begin
                mode = CH_BYPASS;
            end else if (restart) begin
                mode = CH_RESTART;
            end else begin
                mode = CH_RUN;
            end

            case (mode)
                CH_OFF: begin
                    // Pending divisor is kept; it applies on re-enable.
                    cnt_d[ch]  = '0;
                    clk_d[ch]  = 1'b0;
                    tick_d[ch] = 1'b0;
                end
                CH_BYPASS: begin
                    cnt_d[ch]  = '0;
                    clk_d[ch]  = 1'b0;
                    tick_d[ch] = 1'b0;
                    if (pend_q[ch]) begin
                        div_d[ch]  = pdiv_q[ch];
                        pend_d[ch] = 1'b0;
                        // Leaving bypass starts with a high phase and a tick;
                        // staying in bypass keeps tick quiet.
                        clk_d[ch]  = (pdiv_q[ch] >= TWO);
                        tick_d[ch] = (pdiv_q[ch] >= TWO);
                    end
                end
                CH_RESTART: begin
                    div_d[ch]  = n_new;
                    pend_d[ch] = 1'b0;
                    cnt_d[ch]  = '0;
                    clk_d[ch]  = (n_new >= TWO);
                    tick_d[ch] = (n_new >= TWO);
                end
                default: begin
                    c_nxt      = wrap ? '0 : cnt_q[ch] + ONE;
                    cnt_d[ch]  = c_nxt;
                    clk_d[ch]  = (c_nxt < high_time(n));
                    tick_d[ch] = (c_nxt == '0);
                end
            endcase

            // A write accepted on the same edge as a boundary only becomes
            // pending here, so it waits for the following boundary.
            if (accept && (cfg_ch == CH_W'(ch))) begin
                pdiv_d[ch] = cfg_div;
                pend_d[ch] = 1'b1;
            end
        end
    end

    // Channel state registers; reset discards any pending divisor.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            // NOTE: these per-channel arrays are control state, not storage,
            // so every entry is reset explicitly to a known divisor.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                div_q[ch]  <= DIV_RST;
                pdiv_q[ch] <= '0;
                cnt_q[ch]  <= '0;
            end
            pend_q    <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
            en_prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                div_q[ch]  <= div_d[ch];
                pdiv_q[ch] <= pdiv_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
            end
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            en_prev_q <= ch_en;
        end
    end

    // Output clock select: registered divided clock, or clk_in itself for an
    // enabled bypass channel; forced low throughout reset.
    always_comb begin
        clk_out = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rst) begin
                clk_out[ch] = 1'b0;
            end else if (ch_en[ch] && (div_q[ch] < TWO)) begin
                clk_out[ch] = clk_in;
            end else begin
                clk_out[ch] = clk_q[ch];
            end
        end
    end

    assign tick        = tick_q;
    assign cfg_pending = pend_q;

endmodule

// File: tb/tb_clock_divider_mc.sv
// -----------------------------------------------------------------------------
// Testbench for clock_divider_mc (NUM_CH=4, WIDTH=8, DEFAULT_DIV=2).
// Expected per-cycle values of clk_out / tick / cfg_pending are queued as
// stimulus is applied and compared one entry per clk_in edge, 1 time unit
// after the rising edge. The phase-sync section is built only when
// PHASE_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_clock_divider_mc;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic              clk_in = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [WIDTH-1:0]  cfg_div;
    logic [NUM_CH-1:0] cfg_pending;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
`ifdef PHASE_SYNC_EN
    logic              sync_req;
`endif

    always #5 clk_in = ~clk_in;

    clock_divider_mc #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (2)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ch_en       (ch_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_pending (cfg_pending),
        .clk_out     (clk_out),
        .tick        (tick)
`ifdef PHASE_SYNC_EN
        ,
        .sync_req    (sync_req)
`endif
    );

    typedef struct {
        string             tag;
        logic [NUM_CH-1:0] mask;
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tck;
        logic [NUM_CH-1:0] pend;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_vec(input string tag, input logic [NUM_CH-1:0] mask,
                            input logic [NUM_CH-1:0] c, input logic [NUM_CH-1:0] t,
                            input logic [NUM_CH-1:0] p);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.clk  = c;
        e.tck  = t;
        e.pend = p;
        sb.push_back(e);
    endtask

    // One queued entry per character; '1' means high on that cycle.
    task automatic expect_ch(input string tag, input int ch, input string c,
                             input string t, input string p);
        logic [NUM_CH-1:0] m;
        m = NUM_CH'(1) << ch;
        for (int i = 0; i < c.len(); i++) begin
            push_vec(tag, m, (c[i] == "1") ? m : '0, (t[i] == "1") ? m : '0,
                     (p[i] == "1") ? m : '0);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            check({e.tag, "_clk"},  32'(clk_out & e.mask),     32'(e.clk));
            check({e.tag, "_tick"}, 32'(tick & e.mask),        32'(e.tck));
            check({e.tag, "_pend"}, 32'(cfg_pending & e.mask), 32'(e.pend));
        end
    endtask

    initial begin
        rst       = 1'b1;
        ch_en     = '1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
`ifdef PHASE_SYNC_EN
        sync_req  = 1'b0;
`endif

        // Reset state.
        repeat (3) step();
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_pending", 32'(cfg_pending), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);

        // Default divide-by-2 on all channels, high on first edge.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_vec("div2", 4'hF, (i % 2 == 0) ? 4'hF : 4'h0,
                     (i % 2 == 0) ? 4'hF : 4'h0, 4'h0);
        end
        drain();

        // ch1 <- 5, accepted on a wrap edge: old period finishes first.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        check("ch1_ready", 32'(cfg_ready), 32'h1);
        expect_ch("ch1_accept", 1, "1", "1", "1");
        drain();
        cfg_valid = 1'b0;
        expect_ch("ch1_div5", 1, "01110011100", "01000010000", "10000000000");
        drain();

        // ch0 <- 3, then 7 held off until the 3 applies.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        check("ch0_ready_first", 32'(cfg_ready), 32'h1);
        expect_ch("ch0_acc3", 0, "1", "1", "1");
        drain();
        cfg_div = 8'd7;
        check("ch0_ready_blocked_a", 32'(cfg_ready), 32'h0);
        expect_ch("ch0_wait", 0, "0", "0", "1");
        drain();
        check("ch0_ready_blocked_b", 32'(cfg_ready), 32'h0);
        expect_ch("ch0_apply3", 0, "1", "1", "0");
        drain();
        check("ch0_ready_after", 32'(cfg_ready), 32'h1);
        expect_ch("ch0_acc7", 0, "1", "0", "1");
        drain();
        cfg_valid = 1'b0;
        expect_ch("ch0_div3_to_7", 0, "011110001", "010000001", "100000000");
        drain();

        // ch2 <- 0: bypass follows clk_in, no ticks.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
        check("ch2_ready", 32'(cfg_ready), 32'h1);
        expect_ch("ch2_acc0", 2, "0", "0", "1");
        drain();
        cfg_valid = 1'b0;
        expect_ch("ch2_bypass_hi", 2, "111", "000", "000");
        drain();
        @(negedge clk_in); #1;
        check("ch2_bypass_lo", 32'(clk_out[2]), 32'h0);
        check("ch2_bypass_tick", 32'(tick[2]), 32'h0);

        // ch2 <- 4 out of bypass: starts high, then 2 high / 2 low.
        cfg_valid = 1'b1; cfg_div = 8'd4;
        check("ch2_ready_b", 32'(cfg_ready), 32'h1);
        expect_ch("ch2_acc4", 2, "1", "0", "1");
        drain();
        cfg_valid = 1'b0;
        expect_ch("ch2_start4", 2, "1", "1", "0");
        drain();
        @(negedge clk_in); #1;
        check("ch2_registered_hi", 32'(clk_out[2]), 32'h1);
        expect_ch("ch2_div4", 2, "1001100", "0001000", "0000000");
        drain();

        // Reset mid-period with ch3 pending: everything drops, pending lost.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
        step();
        cfg_valid = 1'b0;
        check("ch3_pending_set", 32'(cfg_pending), 32'h8);
        rst = 1'b1;
        #1;
        check("mid_rst_clk_out", 32'(clk_out), 32'h0);
        check("mid_rst_pending", 32'(cfg_pending), 32'h0);
        check("mid_rst_tick", 32'(tick), 32'h0);
        step();
        check("mid_rst_hold", 32'(clk_out), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_vec("post_rst", 4'hF, (i % 2 == 0) ? 4'hF : 4'h0,
                     (i % 2 == 0) ? 4'hF : 4'h0, 4'h0);
        end
        drain();

        // Disabled ch1 keeps a pending write; applied at enable rising.
        ch_en = 4'b1101;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        check("ch1_ready_dis", 32'(cfg_ready), 32'h1);
        expect_ch("ch1_dis_acc", 1, "0", "0", "1");
        drain();
        cfg_valid = 1'b0;
        expect_ch("ch1_dis_hold", 1, "00", "00", "11");
        drain();
        ch_en = 4'hF;
        expect_ch("ch1_en_rise", 1, "1101", "1001", "0000");
        drain();

`ifdef PHASE_SYNC_EN
        // ch0 <- 4, ch1 <- 6, then align both with one sync pulse.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        repeat (12) step();
        check("sync_setup_pending", 32'(cfg_pending), 32'h0);
        sync_req = 1'b1;
        push_vec("sync0", 4'b0011, 4'b0011, 4'b0011, 4'b0000);
        drain();
        sync_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            push_vec("sync_run", 4'b0011,
                     {2'b00, ((i % 6) < 3), ((i % 4) < 2)},
                     {2'b00, ((i % 6) == 0), ((i % 4) == 0)}, 4'b0000);
        end
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
